ozdemir_core: RTL and testbench

//   Multi-cycle RV32I-subset processor core, 4 stages per instruction.

---
 rtl/ozdemir_core.sv | 211 +++++++++++++++++++++
 tb/tb_ozdemir_core.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ozdemir_core.sv
// Multi-cycle RV32I-subset core: FETCH, DECODE, EXECUTE, MEM/WB, one stage per clock.
// Instruction words arrive byte-swapped; data words are used as-is.
module ozdemir_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   inst_i,
  output logic [31:0]   pc_o,
  output logic [1023:0] regs_o,
  output logic          data_mem_we_o,
  output logic [31:0]   data_mem_addr_o,
  output logic [31:0]   data_mem_wdata_o,
  input  logic [31:0]   data_mem_rdata_i,
  output logic [1:0]    cur_stage_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_MEMWB   = 2'd3
  } stage_e;

  stage_e      stage_q, stage_d;
  logic [31:0] pc_q, ir_q, rs1_q, rs2_q, imm_q, result_q, next_pc_q;
  logic [31:0] regs_q [32];
  logic        we_q;
  logic [31:0] addr_q, wdata_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_idx, rs1_idx, rs2_idx;
  logic [31:0] imm_d, op_b, alu_d, result_d, next_pc_d, wb_data;
  logic [4:0]  shamt;
  logic        is_load, is_store, writes_rd, branch_taken;

  assign opcode   = ir_q[6:0];
  assign rd_idx   = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1_idx  = ir_q[19:15];
  assign rs2_idx  = ir_q[24:20];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);

  // State register
  // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) stage_q <= ST_FETCH;
    else       stage_q <= stage_d;
  end

  // Next-state logic
  always_comb begin
    stage_d = ST_FETCH;
    unique case (stage_q)
      ST_FETCH:   stage_d = ST_DECODE;
      ST_DECODE:  stage_d = ST_EXECUTE;
      ST_EXECUTE: stage_d = ST_MEMWB;
      ST_MEMWB:   stage_d = ST_FETCH;
      default:    stage_d = ST_FETCH;
    endcase
  end

  // Output logic
  always_comb begin
    cur_stage_o = stage_q;
  end

  // Immediate generation, selected by instruction format
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    imm_d = {{20{ir_q[31]}}, ir_q[31:20]};
    unique case (opcode)
      OPC_STORE:           imm_d = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OPC_BRANCH:          imm_d = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:  imm_d = {ir_q[31:12], 12'b0};
      OPC_JAL:             imm_d = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:             imm_d = {{20{ir_q[31]}}, ir_q[31:20]};
    endcase
  end

  // ALU; bit 30 selects SUB and SRA/SRAI
  assign op_b  = (opcode == OPC_OP) ? rs2_q : imm_q;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_d = 32'h0;
    unique case (funct3)
      3'b000:  alu_d = (opcode == OPC_OP && ir_q[30]) ? rs1_q - op_b : rs1_q + op_b;
      3'b001:  alu_d = rs1_q << shamt;
      3'b010:  alu_d = {31'b0, $signed(rs1_q) < $signed(op_b)};
      3'b011:  alu_d = {31'b0, rs1_q < op_b};
      3'b100:  alu_d = rs1_q ^ op_b;
      3'b101:  alu_d = ir_q[30] ? 32'($signed(rs1_q) >>> shamt) : rs1_q >> shamt;
      3'b110:  alu_d = rs1_q | op_b;
      3'b111:  alu_d = rs1_q & op_b;
      default: alu_d = 32'h0;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    unique case (funct3)
      3'b000:  branch_taken = (rs1_q == rs2_q);
      3'b001:  branch_taken = (rs1_q != rs2_q);
      3'b100:  branch_taken = ($signed(rs1_q) < $signed(rs2_q));
      3'b101:  branch_taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  branch_taken = (rs1_q < rs2_q);
      3'b111:  branch_taken = (rs1_q >= rs2_q);
      default: branch_taken = 1'b0;
    endcase
  end

  // Result, writeback enable and next PC; unknown opcodes fall through as NOP
  always_comb begin
    result_d  = alu_d;
    next_pc_d = pc_q + 32'd4;
    writes_rd = 1'b0;
    unique case (opcode)
      OPC_LUI:    begin result_d = imm_q;         writes_rd = 1'b1; end
      OPC_AUIPC:  begin result_d = pc_q + imm_q;  writes_rd = 1'b1; end
      OPC_JAL:    begin
        result_d  = pc_q + 32'd4;
        next_pc_d = pc_q + imm_q;
        writes_rd = 1'b1;
      end
      OPC_JALR:   begin
        result_d  = pc_q + 32'd4;
        next_pc_d = (rs1_q + imm_q) & ~32'd1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: if (branch_taken) next_pc_d = pc_q + imm_q;
      OPC_LOAD:   writes_rd = 1'b1;
      OPC_OPIMM, OPC_OP: writes_rd = 1'b1;
      default:    writes_rd = 1'b0;
    endcase
  end

  assign wb_data = is_load ? data_mem_rdata_i : result_q;

  // Datapath registers, advanced by stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      rs1_q     <= 32'h0;
      rs2_q     <= 32'h0;
      imm_q     <= 32'h0;
      result_q  <= 32'h0;
      next_pc_q <= 32'h0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
    end else begin
      unique case (stage_q)
        ST_FETCH:  ir_q <= {inst_i[7:0], inst_i[15:8], inst_i[23:16], inst_i[31:24]};
        ST_DECODE: begin
          rs1_q <= regs_q[rs1_idx];
          rs2_q <= regs_q[rs2_idx];
          imm_q <= imm_d;
        end
        ST_EXECUTE: begin
          result_q  <= result_d;
          next_pc_q <= next_pc_d;
          if (is_load || is_store) addr_q <= rs1_q + imm_q;
          if (is_store) begin
            we_q    <= 1'b1;
            wdata_q <= rs2_q;
          end
        end
        ST_MEMWB: begin
          pc_q <= next_pc_q;
          we_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Register file
  // NOTE: the register file is reset because it is exported and must read all-zero after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else if (stage_q == ST_MEMWB && writes_rd && rd_idx != 5'd0) begin
      regs_q[rd_idx] <= wb_data;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int n = 0; n < 32; n++) regs_o[(31-n)*32 +: 32] = regs_q[n];
  end

  assign pc_o             = pc_q;
  assign data_mem_we_o    = we_q;
  assign data_mem_addr_o  = addr_q;
  assign data_mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_ozdemir_core.sv
// Self-checking bench for ozdemir_core: directed instruction table plus reset corner sequences.
module tb_ozdemir_core;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [31:0]   inst_i;
  logic [31:0]   pc_o;
  logic [1023:0] regs_o;
  logic          data_mem_we_o;
  logic [31:0]   data_mem_addr_o;
  logic [31:0]   data_mem_wdata_o;
  logic [31:0]   data_mem_rdata_i;
  logic [1:0]    cur_stage_o;

  always #5 clk_i = ~clk_i;

  ozdemir_core #(.RESET_PC(32'h0)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .inst_i           (inst_i),
    .pc_o             (pc_o),
    .regs_o           (regs_o),
    .data_mem_we_o    (data_mem_we_o),
    .data_mem_addr_o  (data_mem_addr_o),
    .data_mem_wdata_o (data_mem_wdata_o),
    .data_mem_rdata_i (data_mem_rdata_i),
    .cur_stage_o      (cur_stage_o)
  );

  // Memories: instruction words held in natural encoding, presented byte-swapped
  logic [31:0] imem [64];
  logic [31:0] dmem [64] = '{default: 32'h0};
  int          we_count = 0;
  int          we_bad_stage = 0;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  always_comb inst_i = bswap(imem[pc_o[7:2]]);
  assign data_mem_rdata_i = dmem[data_mem_addr_o[7:2]];

  always @(posedge clk_i) begin
    if (data_mem_we_o) dmem[data_mem_addr_o[7:2]] <= data_mem_wdata_o;
  end

  always @(negedge clk_i) begin
    if (data_mem_we_o) begin
      we_count++;
      if (cur_stage_o != 2'd3) we_bad_stage++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xreg(input int n);
    return regs_o[(31-n)*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] inst;
    int          rd;
    logic [31:0] val;
    logic [31:0] pc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_regs [32];

  task automatic add(input string name, input logic [31:0] addr, input logic [31:0] inst,
                     input int rd, input logic [31:0] val, input logic [31:0] pc);
    vec_t v;
    v.name = name; v.addr = addr; v.inst = inst; v.rd = rd; v.val = val; v.pc = pc;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    logic [1023:0] exp_flat;

    // Executed-order table: instruction, register to check, its value, PC afterwards
    add("lui",      32'h00, 32'h000120B7,  1, 32'h00012000, 32'h04);
    add("addi",     32'h04, 32'h00508093,  1, 32'h00012005, 32'h08);
    add("sw",       32'h08, 32'h00102023,  1, 32'h00012005, 32'h0C);
    add("lw",       32'h0C, 32'h00002103,  2, 32'h00012005, 32'h10);
    add("and",      32'h10, 32'h0020F1B3,  3, 32'h00012005, 32'h14);
    add("addi_x0",  32'h14, 32'h00700013,  0, 32'h00000000, 32'h18);
    add("addi_x6",  32'h18, 32'h00100313,  6, 32'h00000001, 32'h1C);
    add("sub",      32'h1C, 32'h40600233,  4, 32'hFFFFFFFF, 32'h20);
    add("beq",      32'h20, 32'h00208463,  2, 32'h00012005, 32'h28);
    add("bne",      32'h28, 32'h00209463,  2, 32'h00012005, 32'h2C);
    add("jal",      32'h2C, 32'h010002EF,  5, 32'h00000030, 32'h3C);
    add("blt",      32'h3C, 32'h00624463,  7, 32'h00000000, 32'h44);
    add("bltu",     32'h44, 32'h00626463,  7, 32'h00000000, 32'h48);
    add("srli",     32'h48, 32'h01C25413,  8, 32'h0000000F, 32'h4C);
    add("srai",     32'h4C, 32'h41C25493,  9, 32'hFFFFFFFF, 32'h50);
    add("jalr",     32'h50, 32'h06100567, 10, 32'h00000054, 32'h60);
    add("auipc",    32'h60, 32'h00001597, 11, 32'h00001060, 32'h64);
    add("unknown",  32'h64, 32'hFFFFFFFF, 31, 32'h00000000, 32'h68);
    add("sltu",     32'h68, 32'h00433633, 12, 32'h00000001, 32'h6C);
    add("slt",      32'h6C, 32'h006226B3, 13, 32'h00000001, 32'h70);

    // NOPs everywhere, a x7-writing trap on every skipped slot
    for (int i = 0; i < 64; i++) imem[i] = 32'h00000013;
    foreach (imem[i]) begin
      if (i == 9 || i == 12 || i == 13 || i == 14 || i == 16 || i == 21 || i == 22 || i == 23)
        imem[i] = 32'h05500393;
    end
    foreach (vecs[i]) imem[vecs[i].addr[7:2]] = vecs[i].inst;
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;

    // Reset held for two cycles
    rst_i = 1'b1;
    tick();
    tick();
    check("rst_pc",    pc_o, 32'h0);
    check("rst_stage", {30'b0, cur_stage_o}, 32'h0);
    check("rst_regs",  {31'b0, regs_o != '0}, 32'h0);
    check("rst_we",    {31'b0, data_mem_we_o}, 32'h0);
    check("rst_addr",  data_mem_addr_o, 32'h0);
    check("rst_wdata", data_mem_wdata_o, 32'h0);

    // Stage sequence after release, then re-reset
    rst_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("stage_seq%0d", k), {30'b0, cur_stage_o}, 32'(k % 4));
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rerst_x1", xreg(1), 32'h0);
    check("rerst_pc", pc_o, 32'h0);

    // Directed program
    foreach (vecs[i]) begin
      repeat (3) tick();
      if (vecs[i].inst[6:0] == 7'b0100011) begin
        check("sw_we",    {31'b0, data_mem_we_o}, 32'h1);
        check("sw_addr",  data_mem_addr_o, 32'h0);
        check("sw_wdata", data_mem_wdata_o, 32'h00012005);
      end else begin
        check({vecs[i].name, "_we"}, {31'b0, data_mem_we_o}, 32'h0);
      end
      check({vecs[i].name, "_pc_hold"}, pc_o, vecs[i].addr);
      tick();
      exp_regs[vecs[i].rd] = vecs[i].val;
      check({vecs[i].name, "_reg"}, xreg(vecs[i].rd), vecs[i].val);
      check({vecs[i].name, "_pc"}, pc_o, vecs[i].pc);
      check({vecs[i].name, "_stage"}, {30'b0, cur_stage_o}, 32'h0);
    end

    exp_flat = '0;
    for (int n = 0; n < 32; n++) exp_flat[(31-n)*32 +: 32] = exp_regs[n];
    check("all_regs_match", {31'b0, regs_o != exp_flat}, 32'h0);
    check("trap_x7",        xreg(7), 32'h0);
    check("dmem0",          dmem[0], 32'h00012005);
    check("we_pulses",      32'(we_count), 32'd1);
    check("we_only_memwb",  32'(we_bad_stage), 32'd0);

    // Reset during EXECUTE of the store at 0x08
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    snap = we_count;
    repeat (8) tick();
    check("pre_sw_pc", pc_o, 32'h08);
    tick();
    tick();
    check("sw_exec_stage", {30'b0, cur_stage_o}, 32'h2);
    rst_i = 1'b1;
    tick();
    check("abort_we",    {31'b0, data_mem_we_o}, 32'h0);
    check("abort_pc",    pc_o, 32'h0);
    check("abort_stage", {30'b0, cur_stage_o}, 32'h0);
    check("abort_x1",    xreg(1), 32'h0);
    rst_i = 1'b0;
    tick();
    tick();
    check("abort_no_write", 32'(we_count - snap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
